// File: rtl/decode_ctrl_stage_if.sv
// Fetch-to-decode handshake plus the registered ID/EX control bundle.
interface decode_ctrl_stage_if;
    localparam int unsigned INSTR_W = 32;

    logic               IN_VALID;
    logic [INSTR_W-1:0] INSTRUCTION;
    logic               IN_READY;
    logic               STALL;
    logic               FLUSH;
    logic               OUT_VALID;
    logic [2:0]         IMM_SEL;
    logic               OP1_SEL;
    logic               OP2_SEL;
    logic [4:0]         ALU_OPCODE;
    logic [1:0]         MEM_WRITE;
    logic [2:0]         MEM_READ;
    logic               REG_WRITE_ENABLE;
    logic [1:0]         WB_SEL;
    logic [2:0]         BRANCH_JUMP;
    logic               ILLEGAL;
    logic               MULDIV_BUSY;

    // Fetch / hazard side
    modport master (
        output IN_VALID, INSTRUCTION, STALL, FLUSH,
        input  IN_READY, OUT_VALID, IMM_SEL, OP1_SEL, OP2_SEL, ALU_OPCODE,
               MEM_WRITE, MEM_READ, REG_WRITE_ENABLE, WB_SEL, BRANCH_JUMP,
               ILLEGAL, MULDIV_BUSY
    );

    // Decode stage side
    modport slave (
        input  IN_VALID, INSTRUCTION, STALL, FLUSH,
        output IN_READY, OUT_VALID, IMM_SEL, OP1_SEL, OP2_SEL, ALU_OPCODE,
               MEM_WRITE, MEM_READ, REG_WRITE_ENABLE, WB_SEL, BRANCH_JUMP,
               ILLEGAL, MULDIV_BUSY
    );
endinterface

// File: rtl/decode_ctrl_stage.sv
// Registered RV32I(M) ID-stage control generator with valid/ready, stall,
// flush, illegal-instruction bubbling and a multi-cycle hold for M ops.
// Optional feature macro: CTRL_RV32M_EN (M-extension decode + hold counter).
module decode_ctrl_stage #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    decode_ctrl_stage_if.slave    bus
);
    // Opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // Pipeline control encodings
    localparam logic [2:0] I_TYPE = 3'd0, S_TYPE = 3'd1, B_TYPE = 3'd2,
                           U_TYPE = 3'd3, J_TYPE = 3'd4;
    localparam logic       DATA1 = 1'b0, PC = 1'b1;
    localparam logic       DATA2 = 1'b0, IMM = 1'b1;
    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd2, SLT = 5'd3,
                           SLTU = 5'd4, XOR = 5'd5, SRL = 5'd6, SRA = 5'd7,
                           OR = 5'd8, AND = 5'd9, PASS_B = 5'd10;
`ifdef CTRL_RV32M_EN
    localparam logic [4:0] MUL = 5'd11, MULH = 5'd12, MULHSU = 5'd13,
                           MULHU = 5'd14, DIV = 5'd15, DIVU = 5'd16,
                           REM = 5'd17, REMU = 5'd18;
`endif
    localparam logic [1:0] MEM_WRITE_0 = 2'd0, SB = 2'd1, SH = 2'd2, SW = 2'd3;
    localparam logic [2:0] MEM_READ_0 = 3'd0, LB = 3'd1, LH = 3'd2, LW = 3'd3,
                           LBU = 3'd4, LHU = 3'd5;
    localparam logic [1:0] ALU_RESULT = 2'd0, MEM_DATA = 2'd1, PC_PLUS_4 = 2'd2;
    localparam logic [2:0] BRANCH_JUMP_0 = 3'd0, BEQ = 3'd1, BNE = 3'd2,
                           BLT = 3'd3, BGE = 3'd4, BLTU = 3'd5, BGEU = 3'd6,
                           JUMP = 3'd7;

    // Reject hold lengths the 4-bit counter cannot represent
    if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
        $error("MUL_CYCLES must be within 1..15");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
        $error("DIV_CYCLES must be within 1..15");
    end

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [14:0] unused_instr_bits;

    assign opcode            = bus.INSTRUCTION[6:0];
    assign funct3            = bus.INSTRUCTION[14:12];
    assign funct7            = bus.INSTRUCTION[31:25];
    assign unused_instr_bits = {bus.INSTRUCTION[24:15], bus.INSTRUCTION[11:7]};

    logic [2:0] dec_imm_sel;
    logic       dec_op1_sel;
    logic       dec_op2_sel;
    logic [4:0] dec_alu;
    logic [1:0] dec_mem_write;
    logic [2:0] dec_mem_read;
    logic       dec_rwe;
    logic [1:0] dec_wb_sel;
    logic [2:0] dec_bj;
    logic       dec_illegal;
`ifdef CTRL_RV32M_EN
    logic [3:0] dec_hold;
`endif

    // Combinational instruction decode; illegal encodings collapse to a bubble
    always_comb begin
        dec_imm_sel   = I_TYPE;
        dec_op1_sel   = DATA1;
        dec_op2_sel   = DATA2;
        dec_alu       = ADD;
        dec_mem_write = MEM_WRITE_0;
        dec_mem_read  = MEM_READ_0;
        dec_rwe       = 1'b0;
        dec_wb_sel    = ALU_RESULT;
        dec_bj        = BRANCH_JUMP_0;
        dec_illegal   = 1'b0;
`ifdef CTRL_RV32M_EN
        dec_hold      = 4'd0;
`endif
        case (opcode)
            OPC_LOAD: begin
                dec_op2_sel = IMM;
                dec_rwe     = 1'b1;
                dec_wb_sel  = MEM_DATA;
                case (funct3)
                    3'b000:  dec_mem_read = LB;
                    3'b001:  dec_mem_read = LH;
                    3'b010:  dec_mem_read = LW;
                    3'b100:  dec_mem_read = LBU;
                    3'b101:  dec_mem_read = LHU;
                    default: dec_illegal  = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec_op2_sel = IMM;
                dec_rwe     = 1'b1;
                case (funct3)
                    3'b000: dec_alu = ADD;
                    3'b001: begin
                        dec_alu     = SLL;
                        dec_illegal = (funct7 != F7_BASE);
                    end
                    3'b010: dec_alu = SLT;
                    3'b011: dec_alu = SLTU;
                    3'b100: dec_alu = XOR;
                    3'b101: begin
                        dec_alu     = (funct7 == F7_ALT) ? SRA : SRL;
                        dec_illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                    3'b110: dec_alu = OR;
                    default: dec_alu = AND;
                endcase
            end
            OPC_JALR: begin
                dec_op2_sel = IMM;
                dec_rwe     = 1'b1;
                dec_wb_sel  = PC_PLUS_4;
                dec_bj      = JUMP;
                dec_illegal = (funct3 != 3'b000);
            end
            OPC_STORE: begin
                dec_imm_sel = S_TYPE;
                dec_op2_sel = IMM;
                case (funct3)
                    3'b000:  dec_mem_write = SB;
                    3'b001:  dec_mem_write = SH;
                    3'b010:  dec_mem_write = SW;
                    default: dec_illegal   = 1'b1;
                endcase
            end
            OPC_OP: begin
                dec_rwe = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  dec_alu = ADD;
                        3'b001:  dec_alu = SLL;
                        3'b010:  dec_alu = SLT;
                        3'b011:  dec_alu = SLTU;
                        3'b100:  dec_alu = XOR;
                        3'b101:  dec_alu = SRL;
                        3'b110:  dec_alu = OR;
                        default: dec_alu = AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        3'b000:  dec_alu     = SUB;
                        3'b101:  dec_alu     = SRA;
                        default: dec_illegal = 1'b1;
                    endcase
`ifdef CTRL_RV32M_EN
                end else if (funct7 == F7_MEXT) begin
                    case (funct3)
                        3'b000:  dec_alu = MUL;
                        3'b001:  dec_alu = MULH;
                        3'b010:  dec_alu = MULHSU;
                        3'b011:  dec_alu = MULHU;
                        3'b100:  dec_alu = DIV;
                        3'b101:  dec_alu = DIVU;
                        3'b110:  dec_alu = REM;
                        default: dec_alu = REMU;
                    endcase
                    dec_hold = funct3[2] ? 4'(DIV_CYCLES - 1) : 4'(MUL_CYCLES - 1);
`endif
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_imm_sel = U_TYPE;
                dec_op2_sel = IMM;
                dec_alu     = PASS_B;
                dec_rwe     = 1'b1;
            end
            OPC_AUIPC: begin
                dec_imm_sel = U_TYPE;
                dec_op1_sel = PC;
                dec_op2_sel = IMM;
                dec_rwe     = 1'b1;
            end
            OPC_JAL: begin
                dec_imm_sel = J_TYPE;
                dec_op1_sel = PC;
                dec_op2_sel = IMM;
                dec_rwe     = 1'b1;
                dec_wb_sel  = PC_PLUS_4;
                dec_bj      = JUMP;
            end
            OPC_BRANCH: begin
                dec_imm_sel = B_TYPE;
                dec_alu     = SUB;
                case (funct3)
                    3'b000:  dec_bj      = BEQ;
                    3'b001:  dec_bj      = BNE;
                    3'b100:  dec_bj      = BLT;
                    3'b101:  dec_bj      = BGE;
                    3'b110:  dec_bj      = BLTU;
                    3'b111:  dec_bj      = BGEU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase

        if (dec_illegal) begin
            dec_imm_sel   = I_TYPE;
            dec_op1_sel   = DATA1;
            dec_op2_sel   = DATA2;
            dec_alu       = ADD;
            dec_mem_write = MEM_WRITE_0;
            dec_mem_read  = MEM_READ_0;
            dec_rwe       = 1'b0;
            dec_wb_sel    = ALU_RESULT;
            dec_bj        = BRANCH_JUMP_0;
`ifdef CTRL_RV32M_EN
            dec_hold      = 4'd0;
`endif
        end
    end

    logic [2:0] imm_sel_q,   imm_sel_d;
    logic       op1_sel_q,   op1_sel_d;
    logic       op2_sel_q,   op2_sel_d;
    logic [4:0] alu_q,       alu_d;
    logic [1:0] mem_write_q, mem_write_d;
    logic [2:0] mem_read_q,  mem_read_d;
    logic       rwe_q,       rwe_d;
    logic [1:0] wb_sel_q,    wb_sel_d;
    logic [2:0] bj_q,        bj_d;
    logic       valid_q,     valid_d;
    logic       illegal_q,   illegal_d;
    logic       busy;
    logic       in_ready_c;
    logic       accept;
    logic       load_bubble;
    logic       load_dec;

`ifdef CTRL_RV32M_EN
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    logic [0:0] state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    assign busy = (state_q == HOLD);
`else
    assign busy = 1'b0;
`endif

    assign in_ready_c = !bus.STALL && !busy && !bus.FLUSH;
    assign accept     = bus.IN_VALID && in_ready_c;

    // Next-state selection: flush > stall > hold countdown > accept > bubble
    always_comb begin
        load_bubble = 1'b0;
        load_dec    = 1'b0;
        imm_sel_d   = imm_sel_q;
        op1_sel_d   = op1_sel_q;
        op2_sel_d   = op2_sel_q;
        alu_d       = alu_q;
        mem_write_d = mem_write_q;
        mem_read_d  = mem_read_q;
        rwe_d       = rwe_q;
        wb_sel_d    = wb_sel_q;
        bj_d        = bj_q;
        valid_d     = valid_q;
        illegal_d   = illegal_q;
`ifdef CTRL_RV32M_EN
        cnt_d       = cnt_q;
`endif
        if (bus.FLUSH) begin
            load_bubble = 1'b1;
        end else if (bus.STALL) begin
            load_bubble = 1'b0;
        end else if (busy) begin
`ifdef CTRL_RV32M_EN
            cnt_d = cnt_q - 4'd1;
`endif
        end else if (accept) begin
            load_dec = 1'b1;
        end else begin
            load_bubble = 1'b1;
        end

        if (load_bubble) begin
            imm_sel_d   = I_TYPE;
            op1_sel_d   = DATA1;
            op2_sel_d   = DATA2;
            alu_d       = ADD;
            mem_write_d = MEM_WRITE_0;
            mem_read_d  = MEM_READ_0;
            rwe_d       = 1'b0;
            wb_sel_d    = ALU_RESULT;
            bj_d        = BRANCH_JUMP_0;
            valid_d     = 1'b0;
            illegal_d   = 1'b0;
`ifdef CTRL_RV32M_EN
            cnt_d       = 4'd0;
`endif
        end
        if (load_dec) begin
            imm_sel_d   = dec_imm_sel;
            op1_sel_d   = dec_op1_sel;
            op2_sel_d   = dec_op2_sel;
            alu_d       = dec_alu;
            mem_write_d = dec_mem_write;
            mem_read_d  = dec_mem_read;
            rwe_d       = dec_rwe;
            wb_sel_d    = dec_wb_sel;
            bj_d        = dec_bj;
            valid_d     = 1'b1;
            illegal_d   = dec_illegal;
`ifdef CTRL_RV32M_EN
            cnt_d       = dec_hold;
`endif
        end
`ifdef CTRL_RV32M_EN
        state_d = (cnt_d != 4'd0) ? HOLD : IDLE;
`endif
    end

    // ID/EX boundary registers with synchronous reset to the bubble
    always_ff @(posedge CLK) begin
        if (RESET) begin
            imm_sel_q   <= I_TYPE;
            op1_sel_q   <= DATA1;
            op2_sel_q   <= DATA2;
            alu_q       <= ADD;
            mem_write_q <= MEM_WRITE_0;
            mem_read_q  <= MEM_READ_0;
            rwe_q       <= 1'b0;
            wb_sel_q    <= ALU_RESULT;
            bj_q        <= BRANCH_JUMP_0;
            valid_q     <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef CTRL_RV32M_EN
            cnt_q       <= 4'd0;
            state_q     <= IDLE;
`endif
        end else begin
            imm_sel_q   <= imm_sel_d;
            op1_sel_q   <= op1_sel_d;
            op2_sel_q   <= op2_sel_d;
            alu_q       <= alu_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            rwe_q       <= rwe_d;
            wb_sel_q    <= wb_sel_d;
            bj_q        <= bj_d;
            valid_q     <= valid_d;
            illegal_q   <= illegal_d;
`ifdef CTRL_RV32M_EN
            cnt_q       <= cnt_d;
            state_q     <= state_d;
`endif
        end
    end

    assign bus.IN_READY         = in_ready_c;
    assign bus.OUT_VALID        = valid_q;
    assign bus.IMM_SEL          = imm_sel_q;
    assign bus.OP1_SEL          = op1_sel_q;
    assign bus.OP2_SEL          = op2_sel_q;
    assign bus.ALU_OPCODE       = alu_q;
    assign bus.MEM_WRITE        = mem_write_q;
    assign bus.MEM_READ         = mem_read_q;
    assign bus.REG_WRITE_ENABLE = rwe_q;
    assign bus.WB_SEL           = wb_sel_q;
    assign bus.BRANCH_JUMP      = bj_q;
    assign bus.ILLEGAL          = illegal_q;
    assign bus.MULDIV_BUSY      = busy;
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Self-checking bench for decode_ctrl_stage: directed steps followed by
// randomized traffic, all compared against a transaction-level reference.
module tb_decode_ctrl_stage;
    localparam int unsigned MUL_N = 2;
    localparam int unsigned DIV_N = 8;
`ifdef CTRL_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    // Control encodings of the pipeline
    localparam int I_T = 0, S_T = 1, B_T = 2, U_T = 3, J_T = 4;
    localparam int ADD = 0, SUB = 1, SLL = 2, SLT = 3, SLTU = 4, XOR = 5,
                   SRL = 6, SRA = 7, OR = 8, AND = 9, PASS_B = 10, MUL = 11,
                   MULH = 12, MULHSU = 13, MULHU = 14, DIV = 15, DIVU = 16,
                   REM = 17, REMU = 18;
    localparam int WB_ALU = 0, WB_MEM = 1, WB_PC4 = 2;
    localparam int LW = 3, BEQ = 1, JUMP = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_ctrl_stage_if bus ();
    decode_ctrl_stage #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .CLK(clk), .RESET(rst), .bus(bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Lookup tables indexed by funct3 (0 = unlisted for loads/stores/branches)
    int load_tab [8] = '{1, 2, 3, 0, 4, 5, 0, 0};
    int br_tab   [8] = '{1, 2, 0, 0, 3, 4, 5, 6};
    int alu_tab  [8] = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
    int m_tab    [8] = '{MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
    int opc_tab  [9] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h33, 7'h37, 7'h17, 7'h6f, 7'h63};

    // Reference model state: what the registered outputs should hold
    bit          m_known = 1'b0;
    bit          m_valid;
    bit          m_ill;
    logic [20:0] m_ctrl;
    int          m_hold;

    function automatic logic [20:0] pack(int imm, int op1, int op2, int alu, int mw,
                                         int mr, int rwe, int wb, int bj);
        return {3'(imm), 1'(op1), 1'(op2), 5'(alu), 2'(mw), 3'(mr), 1'(rwe), 2'(wb), 3'(bj)};
    endfunction

    function automatic logic [20:0] bubble();
        return pack(I_T, 0, 0, ADD, 0, 0, 0, WB_ALU, 0);
    endfunction

    function automatic logic [20:0] obs_ctrl();
        return {bus.IMM_SEL, bus.OP1_SEL, bus.OP2_SEL, bus.ALU_OPCODE, bus.MEM_WRITE,
                bus.MEM_READ, bus.REG_WRITE_ENABLE, bus.WB_SEL, bus.BRANCH_JUMP};
    endfunction

    // Instruction -> control bundle, illegal flag and EX cycle count
    function automatic void ref_decode(input logic [31:0] ins, output logic [20:0] ctrl,
                                       output bit ill, output int cyc);
        int opc = int'(ins[6:0]);
        int f3  = int'(ins[14:12]);
        int f7  = int'(ins[31:25]);
        int imm = I_T, op1 = 0, op2 = 0, alu = ADD, mw = 0, mr = 0, rwe = 0, wb = WB_ALU, bj = 0;
        ill = 1'b0;
        cyc = 1;
        case (opc)
            'h03: begin mr = load_tab[f3]; ill = (mr == 0); op2 = 1; rwe = 1; wb = WB_MEM; end
            'h13: begin
                op2 = 1; rwe = 1; alu = alu_tab[f3];
                if (f3 == 1) ill = (f7 != 0);
                else if (f3 == 5) begin
                    ill = !(f7 == 0 || f7 == 'h20);
                    if (f7 == 'h20) alu = SRA;
                end
            end
            'h67: begin ill = (f3 != 0); op2 = 1; rwe = 1; wb = WB_PC4; bj = JUMP; end
            'h23: begin ill = (f3 > 2); mw = f3 + 1; imm = S_T; op2 = 1; end
            'h33: begin
                rwe = 1;
                if (f7 == 0) alu = alu_tab[f3];
                else if (f7 == 'h20 && f3 == 0) alu = SUB;
                else if (f7 == 'h20 && f3 == 5) alu = SRA;
                else if (f7 == 1 && M_EN) begin
                    alu = m_tab[f3];
                    cyc = (f3 < 4) ? int'(MUL_N) : int'(DIV_N);
                end else ill = 1'b1;
            end
            'h37: begin imm = U_T; op2 = 1; alu = PASS_B; rwe = 1; end
            'h17: begin imm = U_T; op1 = 1; op2 = 1; rwe = 1; end
            'h6f: begin imm = J_T; op1 = 1; op2 = 1; rwe = 1; wb = WB_PC4; bj = JUMP; end
            'h63: begin imm = B_T; alu = SUB; bj = br_tab[f3]; ill = (bj == 0); end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            ctrl = bubble();
            cyc  = 1;
        end else begin
            ctrl = pack(imm, op1, op2, alu, mw, mr, rwe, wb, bj);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check ready, advance model, check outputs next negedge
    task automatic step(input bit v, input logic [31:0] ins, input bit st, input bit fl,
                        input bit rs);
        logic [20:0] dc;
        bit          ill;
        int          cyc;
        bus.IN_VALID    = v;
        bus.INSTRUCTION = ins;
        bus.STALL       = st;
        bus.FLUSH       = fl;
        rst             = rs;
        #1;
        if (m_known) chk("in_ready", 32'(bus.IN_READY), 32'(!st && !fl && m_hold == 0));
        if (rs || fl) begin
            m_valid = 1'b0; m_ill = 1'b0; m_ctrl = bubble(); m_hold = 0;
        end else if (st) begin
            m_hold = m_hold;
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (v) begin
            ref_decode(ins, dc, ill, cyc);
            m_valid = 1'b1; m_ill = ill; m_ctrl = dc; m_hold = cyc - 1;
        end else begin
            m_valid = 1'b0; m_ill = 1'b0; m_ctrl = bubble();
        end
        if (rs) m_known = 1'b1;
        @(negedge clk);
        if (m_known) begin
            chk("out_valid", 32'(bus.OUT_VALID), 32'(m_valid));
            chk("illegal", 32'(bus.ILLEGAL), 32'(m_ill));
            chk("ctrl", 32'(obs_ctrl()), 32'(m_ctrl));
            chk("muldiv_busy", 32'(bus.MULDIV_BUSY), 32'(m_hold != 0));
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int          sel = $urandom_range(0, 9);
        logic [6:0]  opc = (sel < 9) ? 7'(opc_tab[sel]) : 7'($urandom);
        logic [2:0]  f3  = 3'($urandom_range(0, 7));
        logic [6:0]  f7;
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 10'($urandom), f3, 5'($urandom), opc};
    endfunction

    initial begin
        int lowcnt;
        int divcnt;
        rst             = 1'b1;
        bus.IN_VALID    = 1'b0;
        bus.INSTRUCTION = 32'h0;
        bus.STALL       = 1'b0;
        bus.FLUSH       = 1'b0;
        @(negedge clk);

        // Reset for two cycles, then release
        step(0, 32'h0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 0);
        chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("rst_reg_write", 32'(bus.REG_WRITE_ENABLE), 32'd0);
        chk("rst_mem_write", 32'(bus.MEM_WRITE), 32'd0);
        chk("rst_busy", 32'(bus.MULDIV_BUSY), 32'd0);
        chk("rst_in_ready", 32'(bus.IN_READY), 32'd1);

        // lw x1,4(x2) then beq
        step(1, 32'h00412083, 0, 0, 0);
        chk("lw_mem_read", 32'(bus.MEM_READ), 32'(LW));
        chk("lw_imm_sel", 32'(bus.IMM_SEL), 32'(I_T));
        chk("lw_rwe", 32'(bus.REG_WRITE_ENABLE), 32'd1);
        chk("lw_op2_imm", 32'(bus.OP2_SEL), 32'd1);
        chk("lw_wb_mem", 32'(bus.WB_SEL), 32'(WB_MEM));
        step(1, 32'h00208463, 0, 0, 0);
        chk("beq_bj", 32'(bus.BRANCH_JUMP), 32'(BEQ));
        chk("beq_rwe", 32'(bus.REG_WRITE_ENABLE), 32'd0);

        // div x3,x1,x2: hold length and ready-low window
        step(1, 32'h0220C1B3, 0, 0, 0);
        lowcnt = 0;
        divcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.IN_READY !== 1'b1) lowcnt++;
            if (bus.OUT_VALID === 1'b1 && bus.ALU_OPCODE === 5'(DIV)) divcnt++;
            step(0, 32'h0, 0, 0, 0);
        end
        chk("div_ready_low_cycles", 32'(lowcnt), M_EN ? 32'(DIV_N - 1) : 32'd0);
        chk("div_stable_cycles", 32'(divcnt), M_EN ? 32'(DIV_N) : 32'd0);

        // div then an addi offered back-to-back: model times the second accept
        step(1, 32'h0220C1B3, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 32'h00500093, 0, 0, 0);

        // FLUSH together with STALL in cycle 3 of a hold
        step(1, 32'h0220C1B3, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0);
        step(1, 32'h00500093, 1, 1, 0);
        chk("flush_out_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("flush_busy", 32'(bus.MULDIV_BUSY), 32'd0);
        step(0, 32'h0, 0, 0, 0);
        chk("flush_in_ready", 32'(bus.IN_READY), 32'd1);

        // Illegal opcode bubble
        step(1, 32'hFFFFFFFF, 0, 0, 0);
        chk("ill_flag", 32'(bus.ILLEGAL), 32'd1);
        chk("ill_rwe", 32'(bus.REG_WRITE_ENABLE), 32'd0);
        chk("ill_mem_write", 32'(bus.MEM_WRITE), 32'd0);
        chk("ill_bj", 32'(bus.BRANCH_JUMP), 32'd0);

        // mul: legal multi-cycle op with the M extension, illegal without
        step(1, 32'h022081B3, 0, 0, 0);
        chk("mul_illegal", 32'(bus.ILLEGAL), M_EN ? 32'd0 : 32'd1);
        chk("mul_busy", 32'(bus.MULDIV_BUSY), M_EN ? 32'(MUL_N > 1) : 32'd0);
        chk("mul_in_ready", 32'(bus.IN_READY), M_EN ? 32'(MUL_N == 1) : 32'd1);
        step(0, 32'h0, 0, 0, 0);

        // Randomized traffic with stalls, flushes and occasional resets
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 8, rand_instr(), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
